// File: rtl/uart_rx_if.sv
// Serial-receive bundle: line input plus decoded byte and status strobes.
// Latency: n/a (wiring only).
// Backpressure: none; strobes are single-cycle and are not held for the consumer.
// Signals: rx (serial line, idle high), dout (last good byte), rx_done (byte strobe),
//          frame_err (bad stop bit strobe), busy (frame in progress).
// master = the receiver side, slave = line driver / byte consumer side.
interface uart_rx_if;
   logic       rx;
   logic [7:0] dout;
   logic       rx_done;
   logic       frame_err;
   logic       busy;

   modport master (input rx, output dout, output rx_done, output frame_err, output busy);
   modport slave  (output rx, input dout, input rx_done, input frame_err, input busy);
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, mid-bit sampling with start-bit glitch rejection.
// Latency: strobe about 9.5 bit periods + 2 clocks after the start edge reaches the synchroniser.
// Backpressure: none; rx_done/frame_err are one-cycle pulses, dout holds until the next good frame.
// Ports: clk, rst_n (async active-low), bus (uart_rx_if.master: rx in; dout, rx_done,
//        frame_err, busy out). CLKS_PER_BIT is derived from CLK_HZ/BAUD inside the module.
module uart_rx #(
   parameter int CLK_HZ = 100_000_000,
   parameter int BAUD   = 115200
) (
   input  logic     clk,
   input  logic     rst_n,
   uart_rx_if.master bus
);
   localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
   localparam int CW           = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

   state_t        state, state_n;
   logic [1:0]    sync;
   logic          rx_s;
   logic [CW-1:0] cnt, cnt_n;
   logic [2:0]    bit_idx, bit_idx_n;
   logic [7:0]    shreg, shreg_n;
   logic [7:0]    dout_r, dout_n;
   logic          done_r, done_n;
   logic          ferr_r, ferr_n;

   // Two-flop synchroniser; resets to the idle-high line level so no false start after reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync <= 2'b11;
      else        sync <= {sync[0], bus.rx};
   end
   assign rx_s = sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         dout_r  <= '0;
         done_r  <= 1'b0;
         ferr_r  <= 1'b0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= bit_idx_n;
         shreg   <= shreg_n;
         dout_r  <= dout_n;
         done_r  <= done_n;
         ferr_r  <= ferr_n;
      end
   end

   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      bit_idx_n = bit_idx;
      shreg_n   = shreg;
      dout_n    = dout_r;
      done_n    = 1'b0;
      ferr_n    = 1'b0;
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = '0;
            end
         end
         START: begin
            // Half a bit in: a line still low is a real start bit, otherwise a glitch.
            if (cnt == CNT_MID) begin
               cnt_n     = '0;
               bit_idx_n = '0;
               state_n   = rx_s ? IDLE : DATA;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_n   = '0;
               shreg_n = {rx_s, shreg[7:1]};
               if (bit_idx == 3'd7) state_n   = STOP;
               else                 bit_idx_n = bit_idx + 3'd1;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         STOP: begin
            // Leave at mid stop bit so an early next start edge is still caught.
            if (cnt == CNT_LAST) begin
               cnt_n = '0;
               if (rx_s) begin
                  dout_n  = shreg;
                  done_n  = 1'b1;
                  state_n = IDLE;
               end else begin
                  ferr_n  = 1'b1;
                  state_n = WAIT_HIGH;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         WAIT_HIGH: begin
            // A held-low line (break) must not be decoded as repeated 0x00 frames.
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.dout      = dout_r;
   assign bus.rx_done   = done_r;
   assign bus.frame_err = ferr_r;
   assign bus.busy      = (state != IDLE);
endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver, 8N1, LSB first, for the serial link driven by the team's `tx` transmitter. It synchronises the asynchronous serial input and validates the start bit at mid-bit. It samples each data bit at its centre, checks the stop bit, then presents the received byte with a one-cycle completion strobe. It sits directly downstream of `tx` on the `tx` line, and its timing parameters match the transmitter's.

## Interface
- `CLK_HZ`, default 100_000_000, system clock frequency in Hz.
- `BAUD`, default 115200, line bit rate.
- `CLKS_PER_BIT`, default CLK_HZ/BAUD (integer division, 868), clocks per bit. It is derived and must not be overridden independently.
- `clk`  in  1  system clock, rising-edge active.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `rx`  in  1  serial line, idle high, asynchronous to `clk`.
- `dout`  out  8  last correctly received byte. It is held until the next good frame.
- `rx_done`  out  1  one-cycle pulse when `dout` updates.
- `frame_err`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high while a frame is being received (any state except IDLE).

## Operation
- Input synchronisation:
  - `rx` passes through a 2-flop synchroniser; the output is `rx_s`.
  - Both flops reset to 1 (line idle).
  - All decisions use `rx_s` only.
- Bit counter: 0..CLKS_PER_BIT-1. Bit index counter: 0..7. Shift register: 8 bits, shifts right with the new bit entering the MSB, so the byte is LSB first.
- State machine, reset state IDLE:
  - IDLE: when `rx_s`==0, go to START and clear the counter.
  - START: count to CLKS_PER_BIT/2-1, which is mid start bit.
    - If `rx_s`==0, go to DATA with the counter and bit index cleared.
    - Otherwise the input was a glitch: go to IDLE with no output activity.
  - DATA: at counter==CLKS_PER_BIT-1, shift in `rx_s` and clear the counter.
    - After bit index 7, go to STOP.
    - Otherwise increment the bit index.
  - STOP: at counter==CLKS_PER_BIT-1, sample `rx_s`.
    - If 1: load `dout` from the shift register, pulse `rx_done`, go to IDLE.
    - If 0: pulse `frame_err`, leave `dout` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until `rx_s`==1, then go to IDLE. This prevents a break condition from being decoded as a stream of 0x00 frames.
- Returning to IDLE at mid stop bit is intentional. A following start edge is detected even if the next frame starts early.
- `rx_done` and `frame_err` are never high in the same cycle.
- Reset values, applied asynchronously when `rst_n` is low:
  - `dout`=8'h00, `rx_done`=0, `frame_err`=0, `busy`=0.
  - State IDLE, counters 0, shift register 0.
- Reset mid-frame: the partial frame is discarded and no strobe is produced. After release, the block waits in IDLE for a new falling edge. If the line is low at release, the remainder of the interrupted frame may be decoded as a new frame; the bench must not check this case.

## Timing
- T0 is the first rising edge at which `rx` is sampled 0 by the first synchroniser flop.
- `rx_s` goes low at T0+2. START is entered at T0+3.
- Mid start-bit check is at T0+3+CLKS_PER_BIT/2-1.
- Data bit k (k=0..7) is sampled CLKS_PER_BIT*(k+1) cycles after the start check.
- The stop bit is sampled, and `rx_done`/`frame_err` are asserted, 9*CLKS_PER_BIT cycles after the start check. This is ≈ T0 + 9.5*CLKS_PER_BIT + 2, which is 8248 cycles at the default parameters.
- The bench accepts ±2 cycles on this latency.
- `dout` is valid from the cycle `rx_done` is high and is stable until the next `rx_done`.
- Tolerance: the design must decode correctly with a transmitter bit period within ±2% of CLKS_PER_BIT.
- Minimum accepted start-bit low width is CLKS_PER_BIT/2 cycles. Shorter pulses are rejected as glitches.

## Test plan
- `tx` with `din`=8'h8A drives `rx`, 100 MHz clock, reset released -> exactly one `rx_done` pulse, `dout`=8'h8A, `frame_err` never high, `busy` low afterwards.
- Bench-driven frames 8'h00, then 8'hFF, then 8'h55 back-to-back, stop bit of 1 bit period -> three `rx_done` pulses spaced 10*CLKS_PER_BIT ±2 cycles apart, `dout` = 00, FF, 55 in order.
- Low glitch on `rx` of 300 cycles (< 434), line otherwise idle -> `busy` pulses high then returns to 0; no `rx_done`, no `frame_err`; `dout` keeps its previous value.
- Frame 8'hA5 with stop bit forced 0, then the line held low for 3 bit periods before going high -> one `frame_err` pulse, no `rx_done`, `dout` unchanged; a following good 8'h3C frame gives `rx_done` with `dout`=8'h3C.
- `rst_n` pulsed low during data bit 4 of frame 8'hC3, then a good frame 8'h12 sent after the line has idled -> no strobe for the interrupted frame, `dout`=8'h00 after reset, `rx_done` with `dout`=8'h12 afterwards.
- Transmitter bit period at CLKS_PER_BIT+17 (+2%) and CLKS_PER_BIT-17 (-2%), byte 8'h96 -> `dout`=8'h96 with `rx_done` in both runs.
